// File: rtl/lfsr_pkg.sv
// Shared constants for the LFSR generator family.
//   TAPS_4 / SEED_4   : maximal-length 4-bit polynomial (taps 3,2) and its default seed
//   TAPS_32 / SEED_32 : maximal-length 32-bit polynomial (taps 31,6,5,1) and its default seed
package lfsr_pkg;

  localparam logic [3:0]  TAPS_4  = 4'hC;
  localparam logic [31:0] TAPS_32 = 32'h8000_0062;
  localparam logic [3:0]  SEED_4  = 4'hF;
  localparam logic [31:0] SEED_32 = 32'hFFFF_FFFF;

endpackage

// File: rtl/m_lfsr_step.sv
// One combinational Fibonacci LFSR step.
//   state      : current register value
//   state_next : value after one shift; feedback enters at bit 0
module m_lfsr_step
  import lfsr_pkg::*;
#(
  parameter int unsigned          WIDTH = 32,
  parameter logic [WIDTH-1:0]     TAPS  = WIDTH'(TAPS_32)
) (
  input  logic [WIDTH-1:0] state,
  output logic [WIDTH-1:0] state_next
);

  logic fb;

  assign fb         = ^(state & TAPS);
  assign state_next = {state[WIDTH-2:0], fb};

endmodule

// File: rtl/m_lfsr_prng.sv
// Parametrised Fibonacci LFSR pseudo-random generator with a valid/ready
// output beat of OUT_W bits, runtime seed load, zero-state recovery and a
// beat counter.
//   clk, rst   : clock, synchronous active-high reset
//   i_en       : generation enable
//   i_ready    : consumer takes o_data this cycle
//   i_seed_we  : load i_seed this cycle (zero seed is replaced by SEED)
//   i_seed     : new seed value
//   o_data     : current beat, oldest generated bit in the MSB
//   o_valid    : o_data holds an unconsumed beat
//   o_lockup   : one-cycle pulse when a zero state was replaced by SEED
//   o_state    : LFSR register (debug)
//   o_count    : beats produced since reset / last seed load, wrapping
module m_lfsr_prng
  import lfsr_pkg::*;
#(
  parameter int unsigned      WIDTH = 32,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(TAPS_32),
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(SEED_32),
  parameter int unsigned      OUT_W = 1,
  parameter int unsigned      CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic             i_ready,
  input  logic             i_seed_we,
  input  logic [WIDTH-1:0] i_seed,
  output logic [OUT_W-1:0] o_data,
  output logic             o_valid,
  output logic             o_lockup,
  output logic [WIDTH-1:0] o_state,
  output logic [CNT_W-1:0] o_count
);

  // Parameter sanity, caught at elaboration.
  if (WIDTH < 2) begin : g_chk_width
    $error("m_lfsr_prng: WIDTH must be >= 2");
  end
  if (OUT_W < 1 || OUT_W > WIDTH) begin : g_chk_outw
    $error("m_lfsr_prng: OUT_W must be in 1..WIDTH");
  end
  if (SEED == '0) begin : g_chk_seed
    $error("m_lfsr_prng: SEED must be nonzero");
  end

  logic [WIDTH-1:0] state;
  logic [OUT_W-1:0] data;
  logic             valid;
  logic             lockup;
  logic [CNT_W-1:0] count;

  // Chain of OUT_W single steps; chain[OUT_W] is the state after a full beat.
  logic [OUT_W:0][WIDTH-1:0] chain;
  logic [WIDTH-1:0]          beat;

  assign chain[0] = state;

  for (genvar k = 0; k < OUT_W; k++) begin : g_step
    m_lfsr_step #(
      .WIDTH (WIDTH),
      .TAPS  (TAPS)
    ) u_step (
      .state      (chain[k]),
      .state_next (chain[k+1])
    );
  end

  assign beat = chain[OUT_W];

  logic zero_state;
  logic advance;
  logic drain;

  assign zero_state = (state == '0);
  assign advance    = i_en && (!valid || i_ready);
  assign drain      = valid && i_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= SEED;
      data   <= '0;
      valid  <= 1'b0;
      lockup <= 1'b0;
      count  <= '0;
    end else begin
      lockup <= 1'b0;
      if (i_seed_we) begin
        // Load discards any pending beat; o_data keeps its stale value
        // but is not valid.
        valid <= 1'b0;
        count <= '0;
        if (i_seed == '0) begin
          state  <= SEED;
          lockup <= 1'b1;
        end else begin
          state <= i_seed;
        end
      end else if (zero_state) begin
        // Recovery costs one cycle; the output side may still drain.
        state  <= SEED;
        lockup <= 1'b1;
        if (drain) valid <= 1'b0;
      end else if (advance) begin
        state <= beat;
        data  <= beat[OUT_W-1:0];
        valid <= 1'b1;
        count <= count + CNT_W'(1);
      end else if (drain) begin
        valid <= 1'b0;
      end
    end
  end

  assign o_state  = state;
  assign o_data   = data;
  assign o_valid  = valid;
  assign o_lockup = lockup;
  assign o_count  = count;

endmodule
